ula_arbiter: RTL and testbench
==============================

# ula_arbiter

Two-port round-robin arbiter and sequencer that shares one combinational 8-bit ULA datapath between two requesters. Each requester hands over an operand pair and a 3-bit opcode through a valid/ready handshake. The arbiter drives the shared ULA inputs, waits a fixed settle time, captures the raw result, and returns it to the winning requester through a second handshake. It sits between the operand sources (front-panel/test logic) and the ULA, ahead of the 7-segment display path.

## Interface
- WIDTH, 8: operand/result width; matches the ULA datapath.
- ALU_WAIT, 1: cycles operands are held on the ULA before the result is sampled; legal range 1..15.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a0, req_b0  in  WIDTH each  requester 0 operands.
- req_op0  in  3  requester 0 opcode.
- req_a1, req_b1  in  WIDTH each  requester 1 operands.
- req_op1  in  3  requester 1 opcode.
- alu_a, alu_b  out  WIDTH each  registered operands to the ULA.
- alu_op  out  3  registered opcode to the ULA. Encoding: 000 OR, 001 AND, 010 XOR, 011 NOT a, 100 a+b, 101 a−b, 110 a+1, 111 −a.
- alu_y  in  WIDTH  raw ULA result, before display encoding.
- rsp_valid  out  2  one-hot response valid to the granted requester.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  WIDTH  captured result, shared by both ports.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Winner is chosen combinationally from req_valid and the priority pointer `last`.
  - With one request valid, that requester wins.
  - With both valid, the requester ≠ `last` wins.
  - req_ready[winner]=1 only when req_valid[winner]=1; all other req_ready bits are 0.
  - On a handshake edge: latch the winner's a/b/op into alu_a/alu_b/alu_op, store `gnt`=winner, set `last`=winner, load `wait_cnt`=ALU_WAIT−1, go to ISSUE.
- **ISSUE**
  - alu_* stay stable; req_ready=0.
  - While `wait_cnt`≠0, decrement it each cycle.
  - When `wait_cnt`=0: sample alu_y into rsp_data and go to RESP.
- **RESP**
  - rsp_valid[gnt]=1; rsp_data is stable.
  - When rsp_ready[gnt]=1: clear rsp_valid and go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- alu_a/alu_b/alu_op keep their last value in IDLE; they change only on a new grant.
- The arbiter performs no arithmetic. Width and overflow behaviour belong to the ULA; rsp_data is alu_y bit-exact and truncated to WIDTH.
- **Reset**, including mid-operation: immediately forces IDLE and drops any in-flight operation; no response is issued for it. Reset values:
  - req_ready=00, rsp_valid=00, busy=0.
  - alu_a=alu_b=0, alu_op=000, rsp_data=0.
  - `last`=1, so requester 0 wins the first tie.
  - gnt=0, wait_cnt=0.
- A requester deasserting req_valid before acceptance is legal; the arbiter re-evaluates every IDLE cycle.

## Timing
- Handshake at edge T (IDLE, valid&ready).
- ISSUE occupies cycles T+1 .. T+ALU_WAIT.
- rsp_valid rises after edge T+ALU_WAIT and is visible in cycle T+ALU_WAIT+1.
- Minimum back-to-back period is ALU_WAIT+2 cycles (with rsp_ready held high).
  - ALU_WAIT=1 gives one accept every 3 cycles.
- No request is accepted in ISSUE or RESP; at most one operation is in flight.
- busy rises the cycle after the accept edge and falls the cycle after the response handshake.
- The result is sampled on the last ISSUE edge, so alu_y must settle within ALU_WAIT cycles of the operand change.

## Test plan
1. Reset, then req_valid=01, a0=0x3C, b0=0x0F, op0=100 (ULA model in bench), rsp_ready=11 → req_ready=01 in cycle 0; rsp_valid=01 with rsp_data=0x4B in cycle 2; IDLE in cycle 3.
2. Both requesters held valid continuously, rsp_ready=11 → grants alternate 0,1,0,1 every 3 cycles; req_ready is never 11.
3. Requester 1 op=101, a1=0x05, b1=0x07, rsp_ready=00 for 5 cycles then 10 → rsp_valid=10 holds with rsp_data=0xFE the whole time; clears the cycle after rsp_ready[1] rises; no new accept meanwhile.
4. Assert rst_n=0 during ISSUE of a requester 0 op → all outputs reach their reset values asynchronously; after release, no rsp_valid appears for the dropped op.
5. ALU_WAIT=4, op=111, a=0x01 → rsp_valid in cycle 5 with rsp_data=0xFF; alu_* unchanged in cycles 1-4.
6. rsp_ready=01 while gnt=1 in RESP → ignored; rsp_valid=10 persists.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// ula_arbiter_if: bundle of the request, ULA and response signals of ula_arbiter.
//
// Signals
//   req_valid/req_ready   per-requester operand handshake (bit n = requester n)
//   req_a0/b0/op0         requester 0 operands and opcode
//   req_a1/b1/op1         requester 1 operands and opcode
//   alu_a/alu_b/alu_op    registered operands driven to the shared ULA
//   alu_y                 raw ULA result
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_data              captured result, shared by both ports
//   busy                  arbiter is not idle
//
// Modports
//   slave   the arbiter side
//   master  the requester/ULA side (operand sources, ULA and result sinks)
interface ula_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [2:0]       req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [2:0]       req_op1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, alu_y, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, alu_y, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// ula_arbiter: two-port round-robin arbiter/sequencer sharing one combinational ULA.
//
// A requester's operand pair and opcode are accepted through req_valid/req_ready,
// held on alu_a/alu_b/alu_op for ALU_WAIT cycles, then alu_y is captured into
// rsp_data and returned through rsp_valid/rsp_ready to the granted requester.
// Only one operation is in flight at a time.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; drops any in-flight operation
//   bus    ula_arbiter_if.slave: request, ULA and response signals
//
// Parameters
//   WIDTH     operand/result width (must match the interface)
//   ALU_WAIT  cycles operands are held on the ULA before sampling, 1..15
module ula_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ALU_WAIT = 1
) (
  input logic          clk,
  input logic          rst_n,
  ula_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic [3:0] WaitLoad = 4'(ALU_WAIT - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             winner;
  logic             accept;
  logic             rsp_done;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic             busy;

  // Round-robin: a lone request wins outright; on a tie the port that did not
  // win last time goes first.
  always_comb begin
    winner = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      winner = ~last_q;
    end
  end

  assign accept   = (state_q == StIdle) && bus.req_valid[winner];
  assign rsp_done = (state_q == StResp) && bus.rsp_ready[gnt_q];

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      wait_cnt_q <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 3'b000;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      wait_cnt_q <= wait_cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    wait_cnt_d = wait_cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StIssue;
          gnt_d      = winner;
          last_d     = winner;
          wait_cnt_d = WaitLoad;
          alu_a_d    = winner ? bus.req_a1  : bus.req_a0;
          alu_b_d    = winner ? bus.req_b1  : bus.req_b0;
          alu_op_d   = winner ? bus.req_op1 : bus.req_op0;
        end
      end
      StIssue: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          // Last ISSUE edge: alu_y has had ALU_WAIT cycles to settle.
          rsp_data_d = bus.alu_y;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = 1'b1;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        // Gated by rst_n so req_ready reads 00 while reset is held.
        if (accept && rst_n) begin
          req_ready[winner] = 1'b1;
        end
      end
      StResp: begin
        rsp_valid[gnt_q] = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.busy      = busy;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Testbench for ula_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model; a second instance with ALU_WAIT=4
// covers the longer settle time.
module tb_ula_arbiter;

  localparam int PhIdle  = 0;
  localparam int PhIssue = 1;
  localparam int PhResp  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ula_arbiter_if #(.WIDTH(8)) bus ();
  ula_arbiter_if #(.WIDTH(8)) bus4 ();

  ula_arbiter #(.WIDTH(8), .ALU_WAIT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ula_arbiter #(.WIDTH(8), .ALU_WAIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  function automatic logic [7:0] ula(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op);
    case (op)
      3'b000:  return a | b;
      3'b001:  return a & b;
      3'b010:  return a ^ b;
      3'b011:  return ~a;
      3'b100:  return a + b;
      3'b101:  return a - b;
      3'b110:  return a + 8'd1;
      default: return 8'd0 - a;
    endcase
  endfunction

  assign bus.alu_y  = ula(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus4.alu_y = ula(bus4.alu_a, bus4.alu_b, bus4.alu_op);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase of the single in-flight operation, cycles left to
  // settle, the captured operands and the round-robin memory.
  int         m_phase;
  int         m_left;
  logic       m_last;
  logic       m_gnt;
  logic [7:0] m_a, m_b;
  logic [2:0] m_op;

  logic [1:0] obs_req_ready, obs_rsp_valid;
  logic [7:0] obs_rsp_data;
  logic       obs_busy;

  task automatic model_reset();
    m_phase = PhIdle;
    m_left  = 0;
    m_last  = 1'b1;
    m_gnt   = 1'b0;
    m_a     = 8'h00;
    m_b     = 8'h00;
    m_op    = 3'b000;
  endtask

  // One cycle on the main instance; entered and left 1 time unit after a rising edge.
  task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [2:0] o0, input logic [7:0] a1, input logic [7:0] b1,
                      input logic [2:0] o1, input logic [1:0] rr);
    logic       win;
    logic [1:0] e_rr, e_rv;
    bus.req_valid = v;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = o0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = o1;
    bus.rsp_ready = rr;
    #3;
    win  = (v == 2'b11) ? ~m_last : v[1];
    e_rr = 2'b00;
    e_rv = 2'b00;
    if (m_phase == PhIdle && v != 2'b00) e_rr = win ? 2'b10 : 2'b01;
    if (m_phase == PhResp) e_rv = m_gnt ? 2'b10 : 2'b01;
    obs_req_ready = bus.req_ready;
    obs_rsp_valid = bus.rsp_valid;
    obs_rsp_data  = bus.rsp_data;
    obs_busy      = bus.busy;
    check_eq("req_ready", 32'(bus.req_ready), 32'(e_rr));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    check_eq("busy", 32'(bus.busy), 32'(m_phase != PhIdle));
    check_eq("alu_a", 32'(bus.alu_a), 32'(m_a));
    check_eq("alu_b", 32'(bus.alu_b), 32'(m_b));
    check_eq("alu_op", 32'(bus.alu_op), 32'(m_op));
    if (m_phase == PhResp) check_eq("rsp_data", 32'(bus.rsp_data), 32'(ula(m_a, m_b, m_op)));
    @(posedge clk);
    case (m_phase)
      PhIdle: if (v != 2'b00) begin
        m_gnt   = win;
        m_last  = win;
        m_a     = win ? a1 : a0;
        m_b     = win ? b1 : b0;
        m_op    = win ? o1 : o0;
        m_left  = 1;
        m_phase = PhIssue;
      end
      PhIssue: begin
        m_left--;
        if (m_left == 0) m_phase = PhResp;
      end
      default: if (rr[m_gnt]) m_phase = PhIdle;
    endcase
    #1;
  endtask

  task automatic idle_step(input logic [1:0] rr);
    step(2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000, rr);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous reset values
  // (with v_hold on req_valid), releases it and realigns to edge+1.
  task automatic do_reset(input logic [1:0] v_hold);
    bus.req_valid  = v_hold;
    bus.rsp_ready  = 2'b00;
    bus4.req_valid = 2'b00;
    bus4.rsp_ready = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_alu_a", 32'(bus.alu_a), 32'h0);
    check_eq("rst_alu_b", 32'(bus.alu_b), 32'h0);
    check_eq("rst_alu_op", 32'(bus.alu_op), 32'h0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    check_eq("rst_busy4", 32'(bus4.busy), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  logic [1:0] rr_hist[12];

  initial begin
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_a0 = 8'h00; bus.req_b0 = 8'h00; bus.req_op0 = 3'b000;
    bus.req_a1 = 8'h00; bus.req_b1 = 8'h00; bus.req_op1 = 3'b000;
    bus4.req_valid = 2'b00; bus4.rsp_ready = 2'b00;
    bus4.req_a0 = 8'h00; bus4.req_b0 = 8'h00; bus4.req_op0 = 3'b000;
    bus4.req_a1 = 8'h00; bus4.req_b1 = 8'h00; bus4.req_op1 = 3'b000;
    model_reset();
    @(posedge clk);
    #1;

    // Single request on port 0: 0x3C + 0x0F.
    do_reset(2'b01);
    step(2'b01, 8'h3C, 8'h0F, 3'b100, 8'h00, 8'h00, 3'b000, 2'b11);
    check_eq("t1_accept", 32'(obs_req_ready), 32'h1);
    idle_step(2'b11);
    check_eq("t1_busy_c1", 32'(obs_busy), 32'h1);
    idle_step(2'b11);
    check_eq("t1_rsp_valid", 32'(obs_rsp_valid), 32'h1);
    check_eq("t1_rsp_data", 32'(obs_rsp_data), 32'h4B);
    idle_step(2'b11);
    check_eq("t1_idle_c3", 32'(obs_busy), 32'h0);

    // Both ports continuously valid: grants alternate starting with port 0.
    do_reset(2'b00);
    for (int k = 0; k < 12; k++) begin
      step(2'b11, 8'(k), 8'h11, 3'b010, 8'(k + 100), 8'h22, 3'b001, 2'b11);
      rr_hist[k] = obs_req_ready;
    end
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 0) check_eq("t2_grant", 32'(rr_hist[k]), ((k / 3) % 2 == 0) ? 32'h1 : 32'h2);
      else            check_eq("t2_no_grant", 32'(rr_hist[k]), 32'h0);
    end

    // Port 1: 5 - 7 held in RESP, port-0 rsp_ready ignored, no new accept.
    do_reset(2'b00);
    step(2'b10, 8'h00, 8'h00, 3'b000, 8'h05, 8'h07, 3'b101, 2'b00);
    check_eq("t3_accept", 32'(obs_req_ready), 32'h2);
    step(2'b11, 8'h99, 8'h01, 3'b100, 8'h55, 8'h66, 3'b000, 2'b00);
    for (int k = 0; k < 5; k++) begin
      step(2'b11, 8'h99, 8'h01, 3'b100, 8'h55, 8'h66, 3'b000, (k % 2 == 1) ? 2'b01 : 2'b00);
      check_eq("t3_rsp_valid_hold", 32'(obs_rsp_valid), 32'h2);
      check_eq("t3_rsp_data_hold", 32'(obs_rsp_data), 32'hFE);
      check_eq("t3_no_accept", 32'(obs_req_ready), 32'h0);
    end
    step(2'b00, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000, 2'b10);
    check_eq("t3_rsp_last", 32'(obs_rsp_valid), 32'h2);
    idle_step(2'b00);
    check_eq("t3_rsp_cleared", 32'(obs_rsp_valid), 32'h0);

    // Reset during ISSUE drops the operation.
    step(2'b01, 8'h11, 8'h22, 3'b010, 8'h00, 8'h00, 3'b000, 2'b11);
    do_reset(2'b01);
    for (int k = 0; k < 4; k++) begin
      idle_step(2'b11);
      check_eq("t4_no_rsp", 32'(obs_rsp_valid), 32'h0);
    end

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 3'($urandom),
           8'($urandom), 8'($urandom), 3'($urandom), 2'($urandom_range(0, 3)));
    end

    // ALU_WAIT=4 instance: -0x01.
    bus4.req_valid = 2'b01; bus4.req_a0 = 8'h01; bus4.req_b0 = 8'h5A; bus4.req_op0 = 3'b111;
    bus4.rsp_ready = 2'b01;
    #3;
    check_eq("t5_accept", 32'(bus4.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus4.req_valid = 2'b00;
    bus4.req_a0 = 8'hEE; bus4.req_op0 = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      #3;
      check_eq("t5_alu_a", 32'(bus4.alu_a), 32'h01);
      check_eq("t5_alu_op", 32'(bus4.alu_op), 32'h7);
      check_eq("t5_early_rsp", 32'(bus4.rsp_valid), 32'h0);
      check_eq("t5_busy", 32'(bus4.busy), 32'h1);
      @(posedge clk);
      #1;
    end
    #3;
    check_eq("t5_rsp_valid", 32'(bus4.rsp_valid), 32'h1);
    check_eq("t5_rsp_data", 32'(bus4.rsp_data), 32'hFF);
    @(posedge clk);
    #4;
    check_eq("t5_done", 32'(bus4.rsp_valid), 32'h0);
    check_eq("t5_idle", 32'(bus4.busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
